// File: rtl/rf_scoreboard_pkg.sv
// Shared scoreboard constants: register-file geometry and per-register in-flight counter limits.
package rf_scoreboard_pkg;

    localparam int unsigned NREG     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned SB_CNT_W = 2;
    localparam int unsigned SB_MAX   = (1 << SB_CNT_W) - 1;

endpackage

// File: rtl/rf_sb_counter.sv
// Saturating up/down counter of in-flight writes for one GPR.
// It flags retire-on-zero and issue-on-full attempts.
module rf_sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic busy,
    output logic full,
    output logic underflow,
    output logic overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        busy      = (count_q != '0);
        full      = (count_q == CNT_MAX);
        underflow = dec & ~inc & ~busy;
        overflow  = inc & ~dec & full;
        count_d   = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc & ~dec & ~full) begin
            count_d = count_q + 1'b1;
        end else if (dec & ~inc & busy) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// GPR write scoreboard: counts in-flight writes per register from ID issue to WB retire
// and stalls ID while any source (or a saturated destination) is still pending.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int unsigned NREG  = rf_scoreboard_pkg::NREG,
    parameter int unsigned AW    = rf_scoreboard_pkg::AW,
    parameter int unsigned CNT_W = rf_scoreboard_pkg::SB_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic            id_rs1_en,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_rs2_en,
    input  logic            id_rf_we,
    input  logic [AW-1:0]   id_waddr,
    input  logic            id_fire,
    input  logic            wb_rf_we,
    input  logic [AW-1:0]   wb_waddr,
    input  logic            flush,
    output logic            id_stall,
    output logic [NREG-1:0] busy_vec,
    output logic [2:0]      inflight,
    output logic            sb_err
);

    logic [NREG-1:0] inc_vec, dec_vec;
    logic [NREG-1:0] busy_w, full_w, uflow_w, oflow_w;
    logic            issue, retire, inc_eff, dec_eff;
    logic [2:0]      inflight_q, inflight_d;
    logic            sb_err_q, sb_err_d;

    assign issue  = id_fire & id_rf_we & (id_waddr != '0);
    assign retire = wb_rf_we & (wb_waddr != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue) begin
            inc_vec[id_waddr] = 1'b1;
        end
        if (retire) begin
            dec_vec[wb_waddr] = 1'b1;
        end
    end

    // r0 is hardwired zero, so its status bits are constant and no counter exists for it.
    assign busy_w[0]  = 1'b0;
    assign full_w[0]  = 1'b0;
    assign uflow_w[0] = 1'b0;
    assign oflow_w[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        rf_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .clr       (flush),
            .busy      (busy_w[i]),
            .full      (full_w[i]),
            .underflow (uflow_w[i]),
            .overflow  (oflow_w[i])
        );
    end

    assign id_stall = id_valid & ((id_rs1_en & busy_w[id_rs1])
                                | (id_rs2_en & busy_w[id_rs2])
                                | (id_rf_we & full_w[id_waddr]));

    // inflight follows only the per-register changes that actually take effect.
    assign inc_eff = issue  & ~(|oflow_w);
    assign dec_eff = retire & ~(|uflow_w);

    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (inc_eff & ~dec_eff) begin
            if (inflight_q != 3'd7) begin
                inflight_d = inflight_q + 3'd1;
            end
        end else if (dec_eff & ~inc_eff) begin
            if (inflight_q != 3'd0) begin
                inflight_d = inflight_q - 3'd1;
            end
        end
        sb_err_d = sb_err_q | (~flush & ((|uflow_w) | (|oflow_w)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign busy_vec = busy_w;
    assign inflight = inflight_q;
    assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: hand-computed expectations checked with immediate assertions.
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_rs1_en, id_rs2_en, id_rf_we, id_fire;
    logic [4:0]  id_rs1, id_rs2, id_waddr, wb_waddr;
    logic        wb_rf_we, flush;
    logic        id_stall, sb_err;
    logic [31:0] busy_vec;
    logic [2:0]  inflight;

    int total = 0;
    int bad   = 0;

    rf_scoreboard #(.NREG(32), .AW(5), .CNT_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs1_en (id_rs1_en),
        .id_rs2    (id_rs2),
        .id_rs2_en (id_rs2_en),
        .id_rf_we  (id_rf_we),
        .id_waddr  (id_waddr),
        .id_fire   (id_fire),
        .wb_rf_we  (wb_rf_we),
        .wb_waddr  (wb_waddr),
        .flush     (flush),
        .id_stall  (id_stall),
        .busy_vec  (busy_vec),
        .inflight  (inflight),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_rf_we = 0; id_fire = 0;
        id_rs1 = 0; id_rs2 = 0; id_waddr = 0;
        wb_rf_we = 0; wb_waddr = 0; flush = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #12 reset = 1'b0;
        tick();

        // 1: reset state
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_inflight", {29'd0, inflight}, 32'd0);
        chk("rst_stall", {31'd0, id_stall}, 32'd0);
        chk("rst_err", {31'd0, sb_err}, 32'd0);

        // 2: issue r5, dependent read stalls until the cycle after WB retire
        id_valid = 1; id_rf_we = 1; id_waddr = 5; id_fire = 1;
        #1 chk("issue5_stall", {31'd0, id_stall}, 32'd0);
        tick();
        id_fire = 0; id_rf_we = 0; id_rs1 = 5; id_rs1_en = 1;
        #1;
        chk("dep5_stall", {31'd0, id_stall}, 32'd1);
        chk("dep5_busy", busy_vec, 32'h0000_0020);
        chk("dep5_inflight", {29'd0, inflight}, 32'd1);
        wb_rf_we = 1; wb_waddr = 5;
        #1 chk("ret5_same_cycle_stall", {31'd0, id_stall}, 32'd1);
        tick();
        wb_rf_we = 0;
        #1;
        chk("ret5_next_stall", {31'd0, id_stall}, 32'd0);
        chk("ret5_busy", busy_vec, 32'h0);
        chk("ret5_inflight", {29'd0, inflight}, 32'd0);

        // 3: three issues to r7 saturate its counter
        id_rs1_en = 0; id_rf_we = 1; id_waddr = 7; id_fire = 1;
        tick(); tick(); tick();
        id_fire = 0;
        #1;
        chk("r7_full_stall", {31'd0, id_stall}, 32'd1);
        chk("r7_busy", busy_vec, 32'h0000_0080);
        chk("r7_inflight", {29'd0, inflight}, 32'd3);
        id_fire = 1; wb_rf_we = 1; wb_waddr = 7;
        tick();
        id_fire = 0; wb_rf_we = 0;
        #1;
        chk("r7_incdec_stall", {31'd0, id_stall}, 32'd1);
        chk("r7_incdec_inflight", {29'd0, inflight}, 32'd3);
        chk("r7_incdec_err", {31'd0, sb_err}, 32'd0);
        id_rf_we = 0; wb_rf_we = 1;
        tick(); tick();
        #1 chk("r7_one_left_busy", busy_vec, 32'h0000_0080);
        tick();
        wb_rf_we = 0;
        #1;
        chk("r7_drained_busy", busy_vec, 32'h0);
        chk("r7_drained_inflight", {29'd0, inflight}, 32'd0);

        // 4: r0 is never tracked
        id_rf_we = 1; id_waddr = 0; id_fire = 1; wb_rf_we = 1; wb_waddr = 0;
        id_rs1 = 0; id_rs1_en = 1;
        tick();
        #1;
        chk("r0_stall", {31'd0, id_stall}, 32'd0);
        chk("r0_busy", busy_vec, 32'h0);
        chk("r0_inflight", {29'd0, inflight}, 32'd0);
        chk("r0_err", {31'd0, sb_err}, 32'd0);
        idle();

        // 5: flush overrides same-cycle issue and retire
        id_valid = 1; id_rf_we = 1; id_fire = 1; id_waddr = 3;
        tick();
        id_waddr = 9;
        tick();
        chk("pre_flush_inflight", {29'd0, inflight}, 32'd2);
        chk("pre_flush_busy", busy_vec, 32'h0000_0208);
        flush = 1; wb_rf_we = 1; wb_waddr = 3; id_waddr = 12;
        tick();
        idle();
        #1;
        chk("flush_busy", busy_vec, 32'h0);
        chk("flush_inflight", {29'd0, inflight}, 32'd0);
        chk("flush_err", {31'd0, sb_err}, 32'd0);

        // inflight saturates at 7 after eight distinct issues
        id_valid = 1; id_rf_we = 1; id_fire = 1;
        for (int r = 1; r <= 8; r++) begin
            id_waddr = 5'(r);
            tick();
        end
        chk("sat_inflight", {29'd0, inflight}, 32'd7);
        chk("sat_busy", busy_vec, 32'h0000_01fe);
        idle();
        flush = 1;
        tick();
        flush = 0;

        // 6: retire on empty count sets sticky error; async reset clears it mid-cycle
        wb_rf_we = 1; wb_waddr = 4;
        tick();
        wb_rf_we = 0;
        #1 chk("uflow_err", {31'd0, sb_err}, 32'd1);
        chk("uflow_inflight", {29'd0, inflight}, 32'd0);
        id_valid = 1; id_rf_we = 1; id_fire = 1; id_waddr = 6;
        tick();
        idle();
        #1;
        chk("err_sticky", {31'd0, sb_err}, 32'd1);
        chk("r6_busy", busy_vec, 32'h0000_0040);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_err", {31'd0, sb_err}, 32'd0);
        chk("async_rst_busy", busy_vec, 32'h0);
        chk("async_rst_inflight", {29'd0, inflight}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_err", {31'd0, sb_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
